// File: rtl/ibex_rvfi_trace_streamer_pkg.sv
// Shared types for the RVFI trace streamer: the packed header word, the full
// five-word trace record, and the serializer word-index encoding.
package ibex_rvfi_trace_streamer_pkg;

    localparam int unsigned TraceWordsPerRec = 5;
    localparam int unsigned TraceOrderBits   = 13;

    // Header word W0, listed MSB first so the struct packs into bits [31:0].
    typedef struct packed {
        logic [4:0]                rd_addr;
        logic [3:0]                mem_rmask;
        logic [3:0]                mem_wmask;
        logic                      trap;
        logic                      intr;
        logic                      halt;
        logic [1:0]                mode;
        logic                      dropped;
        logic [TraceOrderBits-1:0] order;
    } trace_hdr_t;

    // One captured retirement record, in the order the words go on the wire.
    typedef struct packed {
        logic [31:0] mem_addr;
        logic [31:0] rd_wdata;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        trace_hdr_t  hdr;
    } trace_rec_t;

    // Serializer word index; the value is also the wire position of the word.
    typedef enum logic [2:0] {
        WORD_HDR   = 3'd0,
        WORD_PC    = 3'd1,
        WORD_INSN  = 3'd2,
        WORD_WDATA = 3'd3,
        WORD_MADDR = 3'd4
    } trace_word_e;

    // Pick one 32-bit wire word out of a record.
    function automatic logic [31:0] rec_word(input trace_rec_t rec, input trace_word_e word);
        logic [31:0] w;
        w = '0;
        case (word)
            WORD_HDR:   w = rec.hdr;
            WORD_PC:    w = rec.pc_rdata;
            WORD_INSN:  w = rec.insn;
            WORD_WDATA: w = rec.rd_wdata;
            WORD_MADDR: w = rec.mem_addr;
            default:    w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ibex_trace_rec_fifo.sv
// Record FIFO for the trace streamer: storage, wrapping pointers, occupancy
// count and full/empty flags. A push while full is accepted only when a pop
// happens in the same cycle.
module ibex_trace_rec_fifo
    import ibex_rvfi_trace_streamer_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  trace_rec_t               i_wdata,
    output trace_rec_t               o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(Depth):0]   o_level
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

    trace_rec_t        r_mem [Depth];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [PtrW:0]     r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == DepthCnt);
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Record storage write.
    // NOTE: the storage array has no reset; r_count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because Depth is a power of two; count tracks +push -pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ibex_rvfi_trace_streamer.sv
// RVFI trace streamer: captures retired-instruction records into a FIFO and
// sends each one as five 32-bit words over a valid/ready port. Records that
// arrive while the FIFO is full are dropped, counted, and flagged in the
// header of the next record that does get through.
module ibex_rvfi_trace_streamer
    import ibex_rvfi_trace_streamer_pkg::*;
#(
    parameter int unsigned Depth        = 8,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      drop_clr_i,
    input  logic                      rvfi_valid,
    input  logic [63:0]               rvfi_order,
    input  logic [31:0]               rvfi_insn,
    input  logic                      rvfi_trap,
    input  logic                      rvfi_halt,
    input  logic                      rvfi_intr,
    input  logic [1:0]                rvfi_mode,
    input  logic [4:0]                rvfi_rd_addr,
    input  logic [31:0]               rvfi_rd_wdata,
    input  logic [31:0]               rvfi_pc_rdata,
    input  logic [31:0]               rvfi_mem_addr,
    input  logic [3:0]                rvfi_mem_rmask,
    input  logic [3:0]                rvfi_mem_wmask,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [31:0]               trace_data_o,
    output logic                      trace_last_o,
    output logic [DropCntWidth-1:0]   drop_cnt_o,
    output logic [$clog2(Depth):0]    fifo_level_o
);

    trace_word_e               r_word;
    trace_word_e               w_word_next;
    logic [DropCntWidth-1:0]   r_drop_cnt;
    logic                      r_drop_pending;
    trace_rec_t                w_new_rec;
    trace_rec_t                w_head;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_xfer;
    logic                      w_pop;
    logic                      w_capture;
    logic                      w_push;
    logic                      w_drop;

    // The last-word handshake frees a slot in the same cycle, so a capture
    // arriving then is pushed rather than dropped.
    assign w_xfer    = !w_empty && trace_ready_i;
    assign w_pop     = w_xfer && (r_word == WORD_MADDR);
    assign w_capture = rvfi_valid && enable_i;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;
    assign drop_cnt_o = r_drop_cnt;

    // Assemble the record to capture from the current RVFI strobe.
    always_comb begin
        w_new_rec               = '0;
        w_new_rec.hdr.rd_addr   = rvfi_rd_addr;
        w_new_rec.hdr.mem_rmask = rvfi_mem_rmask;
        w_new_rec.hdr.mem_wmask = rvfi_mem_wmask;
        w_new_rec.hdr.trap      = rvfi_trap;
        w_new_rec.hdr.intr      = rvfi_intr;
        w_new_rec.hdr.halt      = rvfi_halt;
        w_new_rec.hdr.mode      = rvfi_mode;
        w_new_rec.hdr.dropped   = r_drop_pending;
        w_new_rec.hdr.order     = rvfi_order[TraceOrderBits-1:0];
        w_new_rec.pc_rdata      = rvfi_pc_rdata;
        w_new_rec.insn          = rvfi_insn;
        w_new_rec.rd_wdata      = rvfi_rd_wdata;
        w_new_rec.mem_addr      = rvfi_mem_addr;
    end

    ibex_trace_rec_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_new_rec),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level_o)
    );

    // Saturating drop counter; a clear that coincides with a drop leaves 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (drop_clr_i) begin
            r_drop_cnt <= w_drop ? {{(DropCntWidth-1){1'b0}}, 1'b1} : '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // Remember a gap until the next accepted record carries the flag out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_pending <= 1'b0;
        end else if (w_drop) begin
            r_drop_pending <= 1'b1;
        end else if (w_push) begin
            r_drop_pending <= 1'b0;
        end
    end

    // Serializer state register: the word index of the head record.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word <= WORD_HDR;
        end else begin
            r_word <= w_word_next;
        end
    end

    // Next word index: advance on each handshake, wrap to the header after W4.
    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        w_word_next = r_word;
        if (w_xfer) begin
            if (r_word == WORD_MADDR) begin
                w_word_next = WORD_HDR;
            end else begin
                w_word_next = trace_word_e'(r_word + 3'd1);
            end
        end
    end

    // Stream outputs: data is forced to zero when idle so nothing undefined leaks out.
    always_comb begin
        trace_valid_o = !w_empty;
        trace_data_o  = '0;
        trace_last_o  = 1'b0;
        if (!w_empty) begin
            trace_data_o = rec_word(w_head, r_word);
            trace_last_o = (r_word == WORD_MADDR);
        end
    end

endmodule
